// File: rtl/port_access_scheduler.sv
// Serialises up to three simultaneous port requests onto a single-ported array,
// issuing them in rotating round-robin order and returning results together.
module port_access_scheduler #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              port1_valid_in,
    input  logic              port1_wen_in,
    input  logic [ADDR_W-1:0] port1_addr_in,
    input  logic [DATA_W-1:0] port1_data_in,
    input  logic              port2_valid_in,
    input  logic              port2_wen_in,
    input  logic [ADDR_W-1:0] port2_addr_in,
    input  logic [DATA_W-1:0] port2_data_in,
    input  logic              port3_valid_in,
    input  logic              port3_wen_in,
    input  logic [ADDR_W-1:0] port3_addr_in,
    input  logic [DATA_W-1:0] port3_data_in,
    output logic              ready_out,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        slot_orig_id,
    output logic [DATA_W-1:0] port1_data_out,
    output logic              port1_valid_out,
    output logic [DATA_W-1:0] port2_data_out,
    output logic              port2_valid_out,
    output logic [DATA_W-1:0] port3_data_out,
    output logic              port3_valid_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    logic [2:0]        in_valid;
    logic [2:0]        in_wen;
    logic [ADDR_W-1:0] in_addr [3];
    logic [DATA_W-1:0] in_data [3];

    assign in_valid   = {port3_valid_in, port2_valid_in, port1_valid_in};
    assign in_wen     = {port3_wen_in, port2_wen_in, port1_wen_in};
    assign in_addr[0] = port1_addr_in;
    assign in_addr[1] = port2_addr_in;
    assign in_addr[2] = port3_addr_in;
    assign in_data[0] = port1_data_in;
    assign in_data[1] = port2_data_in;
    assign in_data[2] = port3_data_in;

    state_t            state_q, state_d;
    logic [1:0]        prio_q, prio_d;
    logic [2:0]        req_valid_q, req_valid_d;
    logic [2:0]        req_wen_q, req_wen_d;
    logic [ADDR_W-1:0] req_addr_q [3];
    logic [ADDR_W-1:0] req_addr_d [3];
    logic [DATA_W-1:0] req_data_q [3];
    logic [DATA_W-1:0] req_data_d [3];
    logic [1:0]        ord_q [3];
    logic [1:0]        ord_d [3];
    logic [1:0]        k_q, k_d;
    logic [1:0]        idx_q, idx_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        slot_id_q, slot_id_d;
    logic              ready_q, ready_d;
    logic              cap_pend_q, cap_pend_d;
    logic [1:0]        cap_id_q, cap_id_d;
    logic              cap_wen_q, cap_wen_d;
    logic [DATA_W-1:0] result_q [3];
    logic [DATA_W-1:0] result_d [3];
    logic [DATA_W-1:0] data_out_q [3];
    logic [DATA_W-1:0] data_out_d [3];
    logic [2:0]        valid_out_q, valid_out_d;

    logic [1:0]        ord_acc [3];
    logic [1:0]        k_acc;
    logic [1:0]        cap_idx;
    logic [1:0]        sel;

    // Port id reached j steps after p, wrapping 3 -> 1.
    function automatic logic [1:0] rot(input logic [1:0] p, input logic [1:0] j);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, j};
        return (s > 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    always_comb begin
        ord_acc = '{default: 2'd0};
        k_acc   = 2'd0;
        for (int j = 0; j < 3; j++) begin
            logic [1:0] id;
            id = rot(prio_q, 2'(j));
            if (in_valid[id - 2'd1]) begin
                ord_acc[k_acc] = id;
                k_acc          = k_acc + 2'd1;
            end
        end
    end

    assign cap_idx = cap_id_q - 2'd1;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        req_valid_d = req_valid_q;
        req_wen_d   = req_wen_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        ord_d       = ord_q;
        k_d         = k_q;
        idx_d       = idx_q;
        mem_en_d    = 1'b0;
        mem_wen_d   = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        slot_id_d   = 2'd0;
        // Whatever slot is on the bus this cycle gets its result captured next cycle.
        cap_pend_d  = mem_en_q;
        cap_id_d    = slot_id_q;
        cap_wen_d   = mem_wen_q;
        result_d    = result_q;
        data_out_d  = data_out_q;
        valid_out_d = 3'b000;
        sel         = 2'd0;

        if (cap_pend_q)
            result_d[cap_idx] = cap_wen_q ? req_data_q[cap_idx] : mem_rdata;

        case (state_q)
            IDLE: begin
                if (|in_valid) begin
                    state_d     = ISSUE;
                    req_valid_d = in_valid;
                    req_wen_d   = in_wen;
                    req_addr_d  = in_addr;
                    req_data_d  = in_data;
                    ord_d       = ord_acc;
                    k_d         = k_acc;
                    idx_d       = 2'd1;
                    sel         = ord_acc[0] - 2'd1;
                    mem_en_d    = 1'b1;
                    mem_wen_d   = in_wen[sel];
                    mem_addr_d  = in_addr[sel];
                    mem_wdata_d = in_data[sel];
                    slot_id_d   = ord_acc[0];
                end
            end
            ISSUE: begin
                if (idx_q == k_q) begin
                    state_d = DRAIN;
                end else begin
                    sel         = ord_q[idx_q] - 2'd1;
                    mem_en_d    = 1'b1;
                    mem_wen_d   = req_wen_q[sel];
                    mem_addr_d  = req_addr_q[sel];
                    mem_wdata_d = req_data_q[sel];
                    slot_id_d   = ord_q[idx_q];
                    idx_d       = idx_q + 2'd1;
                end
            end
            DRAIN: begin
                state_d     = RESP;
                valid_out_d = req_valid_q;
                for (int p = 0; p < 3; p++)
                    if (req_valid_q[p]) data_out_d[p] = result_d[p];
            end
            RESP: begin
                state_d = IDLE;
                prio_d  = (prio_q == 2'd3) ? 2'd1 : prio_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 2'd1;
            req_valid_q <= 3'b000;
            req_wen_q   <= 3'b000;
            req_addr_q  <= '{default: '0};
            req_data_q  <= '{default: '0};
            ord_q       <= '{default: 2'd0};
            k_q         <= 2'd0;
            idx_q       <= 2'd0;
            mem_en_q    <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            slot_id_q   <= 2'd0;
            ready_q     <= 1'b1;
            cap_pend_q  <= 1'b0;
            cap_id_q    <= 2'd0;
            cap_wen_q   <= 1'b0;
            result_q    <= '{default: '0};
            data_out_q  <= '{default: '0};
            valid_out_q <= 3'b000;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            req_valid_q <= req_valid_d;
            req_wen_q   <= req_wen_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            ord_q       <= ord_d;
            k_q         <= k_d;
            idx_q       <= idx_d;
            mem_en_q    <= mem_en_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            slot_id_q   <= slot_id_d;
            ready_q     <= ready_d;
            cap_pend_q  <= cap_pend_d;
            cap_id_q    <= cap_id_d;
            cap_wen_q   <= cap_wen_d;
            result_q    <= result_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign ready_out       = ready_q;
    assign mem_en          = mem_en_q;
    assign mem_wen         = mem_wen_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign slot_orig_id    = slot_id_q;
    assign port1_data_out  = data_out_q[0];
    assign port2_data_out  = data_out_q[1];
    assign port3_data_out  = data_out_q[2];
    assign port1_valid_out = valid_out_q[0];
    assign port2_valid_out = valid_out_q[1];
    assign port3_valid_out = valid_out_q[2];

endmodule
